// File: rtl/matrix_pkg.sv
// Shared types and helpers for the matrix loader block.
// Holds the loader FSM state encoding and default sizing constants.
// No logic here; imported by the loader and its index counter.
package matrix_pkg;

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    FIRE,
    WAIT_DONE
  } loader_state_e;

  localparam int SIZE_DEF       = 8;
  localparam int DATA_WIDTH_DEF = 16;

  // Index width for a SIZE-entry dimension, never narrower than one bit.
  function automatic int idx_w(input int size);
    int w;
    w = $clog2(size);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/matrix_index_counter.sv
// Row-major row/col walker across a SIZE x SIZE matrix.
// Updates one cycle after inc/clr; clr has priority over inc.
// No backpressure of its own; the owner only pulses inc on accepted beats.
module matrix_index_counter
  import matrix_pkg::*;
#(
  parameter  int SIZE = SIZE_DEF,
  localparam int IW   = idx_w(SIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          clr,
  output logic [IW-1:0] row,
  output logic [IW-1:0] col,
  output logic          at_last,
  output logic          wrap
);

  localparam logic [IW-1:0] LAST = IW'(SIZE - 1);

  logic [IW-1:0] row_q, row_d;
  logic [IW-1:0] col_q, col_d;

  // Next position: col runs fastest, both wrap to zero after the last element.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr) begin
      row_d = '0;
      col_d = '0;
    end else if (inc) begin
      if (col_q == LAST) begin
        col_d = '0;
        row_d = (row_q == LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Position registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row     = row_q;
  assign col     = col_q;
  assign at_last = (row_q == LAST) && (col_q == LAST);
  assign wrap    = inc && !clr && at_last;

endmodule

// File: rtl/matrix_loader.sv
// Assembles a serial A-then-B element stream into parallel matrices and fires matrix_mult.
// start rises the cycle after the final accepted B beat; arrays then hold until done/timeout.
// in_ready is low from FIRE until the multiplier finishes or the wait times out.
module matrix_loader
  import matrix_pkg::*;
#(
  parameter int SIZE         = SIZE_DEF,
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int DONE_TIMEOUT = 64
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [DATA_WIDTH-1:0]                      in_data,
  input  logic                                       in_last,
  input  logic                                       err_clr,
  output logic [SIZE-1:0][SIZE-1:0][DATA_WIDTH-1:0]  A,
  output logic [SIZE-1:0][SIZE-1:0][DATA_WIDTH-1:0]  B,
  output logic                                       start,
  input  logic                                       mult_done,
  output logic                                       busy,
  output logic                                       frame_err,
  output logic                                       timeout_err
);

  localparam int IW = idx_w(SIZE);
  localparam int CW = $clog2(DONE_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LIM = CW'(DONE_TIMEOUT);

  typedef logic [SIZE-1:0][SIZE-1:0][DATA_WIDTH-1:0] mat_t;

  loader_state_e state_q, state_d;
  logic          start_q, start_d;
  logic          busy_q, busy_d;
  logic          frame_err_q, frame_err_d;
  logic          timeout_err_q, timeout_err_d;
  logic [CW-1:0] to_cnt_q, to_cnt_d;
  mat_t          a_q, a_d;
  mat_t          b_q, b_d;

  logic [IW-1:0] row, col;
  logic          at_last, wrap;
  logic          beat, discard, cnt_inc;
  logic          fe_set, te_set;

  assign in_ready = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign beat     = in_valid && in_ready;
  // in_last anywhere except on the final B element is a misplaced end of frame.
  assign discard  = beat && in_last && !((state_q == LOAD_B) && at_last);
  assign cnt_inc  = beat && !discard;

  matrix_index_counter #(.SIZE(SIZE)) u_idx (
    .clk     (clk),
    .rst     (rst),
    .inc     (cnt_inc),
    .clr     (discard),
    .row     (row),
    .col     (col),
    .at_last (at_last),
    .wrap    (wrap)
  );

  // Frame sequencing, done/timeout wait and sticky error bookkeeping.
  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    fe_set   = 1'b0;
    te_set   = 1'b0;
    case (state_q)
      LOAD_A: begin
        if (discard)   fe_set  = 1'b1;
        else if (wrap) state_d = LOAD_B;
      end
      LOAD_B: begin
        if (discard) begin
          fe_set  = 1'b1;
          state_d = LOAD_A;
        end else if (wrap) begin
          if (in_last) begin
            state_d = FIRE;
          end else begin
            fe_set  = 1'b1;
            state_d = LOAD_A;
          end
        end
      end
      FIRE: begin
        state_d  = WAIT_DONE;
        to_cnt_d = '0;
      end
      WAIT_DONE: begin
        if (mult_done) begin
          state_d = LOAD_A;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
          if (to_cnt_d == TO_LIM) begin
            te_set  = 1'b1;
            state_d = LOAD_A;
          end
        end
      end
      default: state_d = LOAD_A;
    endcase
    frame_err_d   = fe_set | (frame_err_q & ~err_clr);
    timeout_err_d = te_set | (timeout_err_q & ~err_clr);
    start_d       = (state_d == FIRE);
    busy_d        = (state_d == FIRE) || (state_d == WAIT_DONE);
  end

  // Element writes; only accepted, non-discarded beats land in the arrays.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (cnt_inc && (state_q == LOAD_A)) a_d[row][col] = in_data;
    if (cnt_inc && (state_q == LOAD_B)) b_d[row][col] = in_data;
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= LOAD_A;
      start_q       <= 1'b0;
      busy_q        <= 1'b0;
      frame_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      to_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      start_q       <= start_d;
      busy_q        <= busy_d;
      frame_err_q   <= frame_err_d;
      timeout_err_q <= timeout_err_d;
      to_cnt_q      <= to_cnt_d;
    end
  end

  // Matrix storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  assign A           = a_q;
  assign B           = b_q;
  assign start       = start_q;
  assign busy        = busy_q;
  assign frame_err   = frame_err_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_matrix_loader.sv
// Bench for matrix_loader: beat-indexed frame model checked every cycle plus directed literals.
// Inputs change on falling edges; outputs are sampled on falling edges.
// Covers identity frame, gaps, early/missing in_last, timeout with err_clr, and mid-load reset.
module tb_matrix_loader;

  localparam int N  = 8;
  localparam int DW = 16;
  localparam int TO = 4;
  localparam int NN = N * N;

  typedef logic [N-1:0][N-1:0][DW-1:0] mat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          err_clr = 1'b0;
  mat_t          A, B;
  logic          start;
  logic          mult_done = 1'b0;
  logic          busy, frame_err, timeout_err;

  always #5 clk = ~clk;

  matrix_loader #(.SIZE(N), .DATA_WIDTH(DW), .DONE_TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .err_clr     (err_clr),
    .A           (A),
    .B           (B),
    .start       (start),
    .mult_done   (mult_done),
    .busy        (busy),
    .frame_err   (frame_err),
    .timeout_err (timeout_err)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_mat(input string name, input mat_t act, input mat_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int i = 0; i < NN; i++) begin
        if (act[i/N][i%N] !== exp[i/N][i%N]) begin
          $display("FAIL %s: element [%0d][%0d] got %0d expected %0d",
                   name, i/N, i%N, act[i/N][i%N], exp[i/N][i%N]);
          break;
        end
      end
    end
  endtask

  // ---------------- behavioural model (beat position within the frame) ----------------
  int            m_pos   = 0;   // beats accepted so far in this frame, 0..2*NN-1
  int            m_phase = 0;   // 0 loading, 1 firing, 2 waiting for done
  int            m_wcnt  = 0;
  int            m_k;
  bit            m_ferr  = 1'b0;
  bit            m_terr  = 1'b0;
  logic [DW-1:0] ea [NN];
  logic [DW-1:0] eb [NN];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pos = 0; m_phase = 0; m_wcnt = 0; m_ferr = 1'b0; m_terr = 1'b0;
      for (int i = 0; i < NN; i++) begin ea[i] = '0; eb[i] = '0; end
    end else begin
      if (err_clr) begin m_ferr = 1'b0; m_terr = 1'b0; end
      case (m_phase)
        0: if (in_valid) begin
          if (m_pos < NN) begin
            if (in_last) begin m_ferr = 1'b1; m_pos = 0; end
            else begin ea[m_pos] = in_data; m_pos++; end
          end else begin
            m_k = m_pos - NN;
            if (m_k == NN - 1) begin
              eb[m_k] = in_data;
              m_pos = 0;
              if (in_last) m_phase = 1;
              else         m_ferr  = 1'b1;
            end else if (in_last) begin
              m_ferr = 1'b1; m_pos = 0;
            end else begin
              eb[m_k] = in_data; m_pos++;
            end
          end
        end
        1: begin m_phase = 2; m_wcnt = 0; end
        default: begin
          if (mult_done) m_phase = 0;
          else begin
            m_wcnt++;
            if (m_wcnt == TO) begin m_terr = 1'b1; m_phase = 0; end
          end
        end
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  bit   chk_en = 1'b0;
  int   start_cnt = 0;
  int   busy_cnt  = 0;
  mat_t exp_a, exp_b;

  always @(negedge clk) begin
    start_cnt += int'(start === 1'b1);
    busy_cnt  += int'(busy === 1'b1);
    if (!rst && chk_en) begin
      for (int i = 0; i < NN; i++) begin
        exp_a[i/N][i%N] = ea[i];
        exp_b[i/N][i%N] = eb[i];
      end
      chk("in_ready",    in_ready,    m_phase == 0);
      chk("start",       start,       m_phase == 1);
      chk("busy",        busy,        m_phase != 0);
      chk("frame_err",   frame_err,   m_ferr);
      chk("timeout_err", timeout_err, m_terr);
      chk_mat("A_array", A, exp_a);
      chk_mat("B_array", B, exp_b);
    end
  end

  // ---------------- stimulus ----------------
  logic [DW-1:0] src_a [NN];
  logic [DW-1:0] src_b [NN];

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Streams nbeats of the frame; bad_pos raises in_last early and ends the frame there.
  task automatic send_frame(input int gap_pct, input int bad_pos, input bit drop_last, input int nbeats);
    for (int i = 0; i < nbeats; i++) begin
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        in_valid = 1'b0;
        in_data  = DW'($urandom);
        in_last  = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = (i < NN) ? src_a[i] : src_b[i-NN];
      in_last  = (i == bad_pos) || ((i == 2*NN-1) && !drop_last);
      @(negedge clk);
      if (i == bad_pos) break;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Pulse mult_done n cycles after the start cycle we are currently in.
  task automatic finish_wait(input int n);
    repeat (n) @(negedge clk);
    mult_done = 1'b1;
    @(negedge clk);
    mult_done = 1'b0;
  endtask

  int s0, b0;

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_start", start, 0);
    chk("reset_busy", busy, 0);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_timeout_err", timeout_err, 0);
    chk("reset_A_zero", A === '0, 1);
    chk("reset_B_zero", B === '0, 1);
    rst = 1'b0;
    chk_en = 1'b1;
    idle(1);

    // Identity A, ramp B, done three cycles after start.
    for (int i = 0; i < NN; i++) begin
      src_a[i] = DW'((i / N) == (i % N));
      src_b[i] = DW'(i);
    end
    s0 = start_cnt; b0 = busy_cnt;
    send_frame(0, -1, 1'b0, 2*NN);
    chk("t1_start_after_last", start, 1);
    finish_wait(3);
    idle(3);
    chk("t1_start_cycles", start_cnt - s0, 1);
    chk("t1_busy_cycles", busy_cnt - b0, 4);
    chk("t1_A00", A[0][0], 1);
    chk("t1_A33", A[3][3], 1);
    chk("t1_A34", A[3][4], 0);
    chk("t1_B25", B[2][5], 21);
    chk("t1_B77", B[7][7], 63);
    chk("t1_ready_back", in_ready, 1);
    chk("t1_no_err", {frame_err, timeout_err}, 0);

    // 50% valid duty with new data.
    for (int i = 0; i < NN; i++) begin
      src_a[i] = DW'(i * 3 + 7);
      src_b[i] = DW'(16'hFFFF - i);
    end
    s0 = start_cnt;
    send_frame(50, -1, 1'b0, 2*NN);
    chk("t2_start_after_last", start, 1);
    finish_wait(1);
    idle(2);
    chk("t2_A12", A[1][2], 37);
    chk("t2_B01", B[0][1], 16'hFFFE);
    chk("t2_start_cycles", start_cnt - s0, 1);

    // Early in_last on B[0][5], then a clean frame.
    for (int i = 0; i < NN; i++) src_b[i] = DW'(1000 + i);
    s0 = start_cnt;
    send_frame(0, NN + 5, 1'b0, 2*NN);
    chk("t3_frame_err", frame_err, 1);
    chk("t3_B05_kept", B[0][5], 16'hFFFF - 5);
    chk("t3_B04_new", B[0][4], 1004);
    chk("t3_ready", in_ready, 1);
    idle(2);
    chk("t3_no_start", start_cnt - s0, 0);
    send_frame(0, -1, 1'b0, 2*NN);
    chk("t3_clean_start", start, 1);
    finish_wait(2);
    idle(2);
    chk("t3_err_sticky", frame_err, 1);
    chk("t3_B05_clean", B[0][5], 1005);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("t3_err_cleared", frame_err, 0);

    // Missing in_last on the final beat.
    for (int i = 0; i < NN; i++) src_b[i] = DW'(2000 + i);
    s0 = start_cnt;
    send_frame(0, -1, 1'b1, 2*NN);
    chk("t4_frame_err", frame_err, 1);
    chk("t4_start_low", start, 0);
    chk("t4_ready", in_ready, 1);
    idle(3);
    chk("t4_no_start", start_cnt - s0, 0);
    chk("t4_B77_written", B[7][7], 2063);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    idle(1);

    // Timeout with mult_done held low, then err_clr racing a new frame error.
    send_frame(0, -1, 1'b0, 2*NN);
    chk("t5_start", start, 1);
    repeat (4) @(negedge clk);
    chk("t5_not_yet", timeout_err, 0);
    @(negedge clk);
    chk("t5_timeout", timeout_err, 1);
    chk("t5_ready", in_ready, 1);
    chk("t5_busy_low", busy, 0);
    in_valid = 1'b1; in_last = 1'b1; in_data = 16'h1234; err_clr = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; err_clr = 1'b0;
    chk("t5_set_wins", frame_err, 1);
    chk("t5_timeout_cleared", timeout_err, 0);
    idle(1);

    // Reset after 40 beats of a new frame.
    for (int i = 0; i < NN; i++) src_a[i] = DW'(500 + i);
    send_frame(0, -1, 1'b0, 40);
    #2 rst = 1'b1;
    #1;
    chk("t6_A_zero", A === '0, 1);
    chk("t6_B_zero", B === '0, 1);
    chk("t6_frame_err", frame_err, 0);
    chk("t6_start", start, 0);
    chk("t6_busy", busy, 0);
    chk("t6_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    s0 = start_cnt;
    send_frame(0, -1, 1'b0, 2*NN);
    chk("t6_start_after_last", start, 1);
    finish_wait(1);
    idle(2);
    chk("t6_A00", A[0][0], 500);
    chk("t6_A47", A[4][7], 539);
    chk("t6_B00", B[0][0], 2000);
    chk("t6_start_cycles", start_cnt - s0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
